// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO block:
// register addresses, STATUS bit positions and UART states.
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_LED    = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_TXDATA = 32'hFFFF_0004;
    localparam logic [31:0] MMIO_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] MMIO_CYCLE  = 32'hFFFF_000C;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    // Word-granular address match; the byte offset is don't-care.
    function automatic logic word_hit(
        input logic [31:0] a,
        input logic [31:0] reg_addr
    );
        return a[31:2] == reg_addr[31:2];
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART serializer: pulls bytes from a FIFO through a
// valid/pop handshake and shifts them out LSB first.
module uart_tx_core
    import dmem_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_pop,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   r_state;
    uart_state_t   w_state_nx;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_nx;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nx;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nx;
    logic          w_baud_end;

    assign w_baud_end = (r_baud == BAUD_LAST);
    assign o_busy     = (r_state != UART_IDLE);

    // State, baud counter, bit counter and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= UART_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
        end
    end

    // Next state, line level and FIFO pop; the line is
    // decoded from state so reset forces it high at once.
    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        o_pop      = 1'b0;
        o_tx       = 1'b1;
        unique case (r_state)
            UART_IDLE: begin
                if (i_valid) begin
                    o_pop      = 1'b1;
                    w_shift_nx = i_data;
                    w_baud_nx  = '0;
                    w_state_nx = UART_START;
                end
            end
            UART_START: begin
                o_tx = 1'b0;
                if (w_baud_end) begin
                    w_baud_nx  = '0;
                    w_bit_nx   = '0;
                    w_state_nx = UART_DATA;
                end else begin
                    w_baud_nx = r_baud + 1'b1;
                end
            end
            UART_DATA: begin
                o_tx = r_shift[0];
                if (w_baud_end) begin
                    w_baud_nx  = '0;
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nx = UART_STOP;
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nx = r_baud + 1'b1;
                end
            end
            UART_STOP: begin
                if (w_baud_end) begin
                    w_baud_nx = '0;
                    if (i_valid) begin
                        o_pop      = 1'b1;
                        w_shift_nx = i_data;
                        w_state_nx = UART_START;
                    end else begin
                        w_state_nx = UART_IDLE;
                    end
                end else begin
                    w_baud_nx = r_baud + 1'b1;
                end
            end
            default: w_state_nx = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus memory-mapped LED, cycle counter and a
// FIFO-buffered UART transmitter for the single-cycle CPU.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS    = 256,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic [15:0] led
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_LIM = 32'(RAM_WORDS);

    logic [31:0]   r_ram [RAM_WORDS];
    logic [15:0]   r_led;
    logic [31:0]   r_cycle;
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [1:0]    r_wptr;
    logic [1:0]    r_rptr;
    logic [2:0]    r_count;
    logic          r_ovf;

    logic [AW-1:0] w_ram_idx;
    logic          w_sel_ram;
    logic          w_sel_led;
    logic          w_sel_tx;
    logic          w_sel_stat;
    logic          w_sel_cyc;
    logic          w_full;
    logic          w_empty;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_evt;
    logic          w_busy;
    logic [31:0]   w_status;
    logic          w_unused_addr;

    assign w_unused_addr = &{1'b0, addr[1:0]};

    assign w_ram_idx  = addr[AW+1:2];
    assign w_sel_ram  = (addr[31:AW+2] == '0) &&
                        ({{(32-AW){1'b0}}, w_ram_idx} < RAM_LIM);
    assign w_sel_led  = word_hit(addr, MMIO_LED);
    assign w_sel_tx   = word_hit(addr, MMIO_TXDATA);
    assign w_sel_stat = word_hit(addr, MMIO_STATUS);
    assign w_sel_cyc  = word_hit(addr, MMIO_CYCLE);

    assign w_full     = (r_count == 3'(FIFO_DEPTH));
    assign w_empty    = (r_count == 3'd0);
    assign w_push_req = mem_w && w_sel_tx;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt  = w_push_req && !w_push;

    assign led = r_led;

    always_comb begin
        w_status           = '0;
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_BUSY]  = w_busy;
        w_status[ST_OVF]   = r_ovf;
    end

    // Load path: purely combinational from addr.
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            w_sel_ram:  rdata = r_ram[w_ram_idx];
            w_sel_led:  rdata = {16'h0, r_led};
            w_sel_stat: rdata = w_status;
            w_sel_cyc:  rdata = r_cycle;
            default:    rdata = '0;
        endcase
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_w && w_sel_ram) begin
            r_ram[w_ram_idx] <= wdata;
        end
    end

    // LED register and free-running cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led   <= '0;
            r_cycle <= '0;
        end else begin
            if (mem_w && w_sel_led) begin
                r_led <= wdata[15:0];
            end
            r_cycle <= (mem_w && w_sel_cyc) ? wdata
                                            : r_cycle + 32'd1;
        end
    end

    // FIFO byte storage, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 3'd1;
            end
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (mem_w && w_sel_stat && wdata[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk    (clk),
        .reset  (reset),
        .i_valid(!w_empty),
        .i_data (r_fifo[r_rptr]),
        .o_pop  (w_pop),
        .o_tx   (uart_tx),
        .o_busy (w_busy)
    );

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: expectations are queued by
// the driver and drained by monitors sampling the DUT.
module tb_dmem_mmio;

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_TX   = 32'hFFFF_0004;
    localparam logic [31:0] A_STAT = 32'hFFFF_0008;
    localparam logic [31:0] A_CYC  = 32'hFFFF_000C;

    localparam int K_RDATA = 0;
    localparam int K_TX    = 1;
    localparam int K_LED   = 2;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    logic        clk;
    logic        reset;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        uart_tx;
    logic [15:0] led;

    chk_t        chk_q[$];
    logic [7:0]  rx_exp_q[$];
    logic        strobe;
    event        ev_async;
    int          n_cmp;
    int          n_bad;
    int          rx_count;

    dmem_mmio #(
        .RAM_WORDS   (256),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mem_w  (mem_w),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .uart_tx(uart_tx),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drain();
        while (chk_q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = chk_q.pop_front();
            case (c.kind)
                K_RDATA: act = rdata;
                K_TX:    act = {31'b0, uart_tx};
                default: act = {16'b0, led};
            endcase
            n_cmp++;
            if (act !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got 0x%08h, want 0x%08h",
                         c.name, act, c.exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (strobe) drain();
    end

    always @(ev_async) drain();

    task automatic expect_v(string n, int k, logic [31:0] e);
        chk_t c;
        c.name = n;
        c.kind = k;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    task automatic cyc(logic we, logic [31:0] a, logic [31:0] d);
        mem_w  = we;
        addr   = a;
        wdata  = d;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        mem_w  = 1'b0;
    endtask

    // UART receiver: samples mid-bit at 4 clocks per bit.
    initial begin : rx_mon
        logic [7:0] b;
        logic       bad_frame;
        logic       aborted;
        forever begin
            @(negedge uart_tx);
            if (reset === 1'b1) begin
                aborted   = 1'b0;
                bad_frame = 1'b0;
                b         = '0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                if (!reset) aborted = 1'b1;
                if (uart_tx !== 1'b0) bad_frame = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    if (!reset) aborted = 1'b1;
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clk);
                if (!reset) aborted = 1'b1;
                if (uart_tx !== 1'b1) bad_frame = 1'b1;
                if (!aborted) begin
                    rx_count++;
                    n_cmp++;
                    if (rx_exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL rx_byte: got 0x%02h, want none", b);
                    end else begin
                        logic [7:0] e;
                        e = rx_exp_q.pop_front();
                        if (b !== e || bad_frame) begin
                            n_bad++;
                            $display("FAIL rx_byte: got 0x%02h framing_err=%0b, want 0x%02h",
                                     b, bad_frame, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin : drive
        logic [7:0]  a5;
        logic        etx;
        logic [31:0] est;
        a5       = 8'hA5;
        n_cmp    = 0;
        n_bad    = 0;
        rx_count = 0;
        strobe   = 1'b0;
        reset    = 1'b0;
        mem_w    = 1'b0;
        addr     = '0;
        wdata    = '0;
        repeat (3) @(posedge clk);
        #1;

        expect_v("rst_cycle", K_RDATA, 32'h0);
        expect_v("rst_tx", K_TX, 32'h1);
        expect_v("rst_led", K_LED, 32'h0);
        cyc(1'b0, A_CYC, 32'h0);
        expect_v("rst_status", K_RDATA, 32'h2);
        cyc(1'b0, A_STAT, 32'h0);

        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_v("cycle_first", K_RDATA, 32'h1);
        cyc(1'b0, A_CYC, 32'h0);

        cyc(1'b1, 32'h10, 32'h1111_1111);
        expect_v("ram_same_cycle", K_RDATA, 32'h1111_1111);
        cyc(1'b1, 32'h10, 32'hDEAD_BEEF);
        expect_v("ram_read", K_RDATA, 32'hDEAD_BEEF);
        cyc(1'b0, 32'h10, 32'h0);
        expect_v("ram_read_bytesel", K_RDATA, 32'hDEAD_BEEF);
        cyc(1'b0, 32'h13, 32'h0);

        cyc(1'b1, A_CYC, 32'hFFFF_FFFE);
        expect_v("cycle_load", K_RDATA, 32'hFFFF_FFFE);
        cyc(1'b0, A_CYC, 32'h0);
        expect_v("cycle_max", K_RDATA, 32'hFFFF_FFFF);
        cyc(1'b0, A_CYC, 32'h0);
        expect_v("cycle_wrap", K_RDATA, 32'h0);
        cyc(1'b0, A_CYC, 32'h0);

        cyc(1'b1, A_LED, 32'h1234_BEEF);
        expect_v("led_read", K_RDATA, 32'h0000_BEEF);
        expect_v("led_port", K_LED, 32'h0000_BEEF);
        cyc(1'b0, A_LED, 32'h0);

        cyc(1'b1, 32'h0, 32'h1234_5678);
        expect_v("unmapped_read", K_RDATA, 32'h0);
        cyc(1'b0, 32'h0001_0000, 32'h0);
        cyc(1'b1, 32'h0001_0000, 32'hCAFE_F00D);
        expect_v("unmapped_ram0", K_RDATA, 32'h1234_5678);
        cyc(1'b0, 32'h0, 32'h0);
        expect_v("unmapped_led", K_RDATA, 32'h0000_BEEF);
        cyc(1'b0, A_LED, 32'h0);
        expect_v("unmapped_status", K_RDATA, 32'h2);
        cyc(1'b0, A_STAT, 32'h0);
        expect_v("unmapped_hi_read", K_RDATA, 32'h0);
        cyc(1'b0, 32'hFFFF_0010, 32'h0);

        rx_exp_q.push_back(8'hA5);
        expect_v("txdata_read", K_RDATA, 32'h0);
        expect_v("a5_tx_pre", K_TX, 32'h1);
        cyc(1'b1, A_TX, 32'h0000_00A5);
        for (int i = 0; i <= 41; i++) begin
            if (i == 0) begin
                etx = 1'b1; est = 32'h0;
            end else if (i <= 4) begin
                etx = 1'b0; est = 32'h6;
            end else if (i <= 36) begin
                etx = a5[(i - 5) / 4]; est = 32'h6;
            end else if (i <= 40) begin
                etx = 1'b1; est = 32'h6;
            end else begin
                etx = 1'b1; est = 32'h2;
            end
            expect_v($sformatf("a5_tx_%0d", i), K_TX, {31'b0, etx});
            expect_v($sformatf("a5_status_%0d", i), K_RDATA, est);
            cyc(1'b0, A_STAT, 32'h0);
        end

        for (int k = 0; k < 6; k++) begin
            if (k < 5) rx_exp_q.push_back(8'(8'h31 + k));
            cyc(1'b1, A_TX, 32'(32'h31 + k));
        end
        expect_v("ovf_status", K_RDATA, 32'hD);
        cyc(1'b1, A_STAT, 32'h8);
        expect_v("ovf_cleared", K_RDATA, 32'h5);
        cyc(1'b0, A_STAT, 32'h0);
        repeat (215) @(posedge clk);
        #1;
        expect_v("ovf_drained", K_RDATA, 32'h2);
        cyc(1'b0, A_STAT, 32'h0);

        cyc(1'b1, A_TX, 32'h0000_0050);
        repeat (18) @(posedge clk);
        #1;
        expect_v("abort_bit3_tx", K_TX, 32'h0);
        -> ev_async;
        #1;
        addr  = A_STAT;
        reset = 1'b0;
        #1;
        expect_v("abort_tx", K_TX, 32'h1);
        expect_v("abort_status", K_RDATA, 32'h2);
        expect_v("abort_led", K_LED, 32'h0);
        -> ev_async;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_v("abort_cycle", K_RDATA, 32'h1);
        cyc(1'b0, A_CYC, 32'h0);
        expect_v("abort_ram_kept", K_RDATA, 32'hDEAD_BEEF);
        expect_v("abort_tx_idle", K_TX, 32'h1);
        cyc(1'b0, 32'h10, 32'h0);
        repeat (60) @(posedge clk);
        #1;
        expect_v("post_status", K_RDATA, 32'h2);
        cyc(1'b0, A_STAT, 32'h0);

        n_cmp++;
        if (rx_count != 6 || rx_exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rx_frames: got %0d frames (%0d pending), want 6 (0 pending)",
                     rx_count, rx_exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter RAM_WORDS, default 256: number of 32-bit data RAM words.
REQ-002 Parameter CLKS_PER_BIT, default 868: clk cycles per UART bit (100 MHz / 115200).
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port mem_w, input, 1: CPU store strobe, word-wide.
REQ-006 The block SHALL have port addr, input, 32: CPU byte address (ALU result).
REQ-007 The block SHALL have port wdata, input, 32: CPU store data.
REQ-008 The block SHALL have port rdata, output, 32: load data returned to CPU.
REQ-009 The block SHALL have port uart_tx, output, 1: serial line, idle high.
REQ-010 The block SHALL have port led, output, 16: LED register contents.

Function
REQ-011 Address map SHALL be:
- RAM at 0x0000_0000 to 4*RAM_WORDS-1, word index addr[log2(RAM_WORDS)+1:2].
- LED at 0xFFFF_0000, RW, bits[15:0].
- TXDATA at 0xFFFF_0004, W.
- STATUS at 0xFFFF_0008, R/W1C.
- CYCLE at 0xFFFF_000C, RW.
REQ-012 addr[1:0] SHALL be ignored; all accesses are word accesses.
REQ-013 rdata SHALL be combinational from addr in the same cycle (single-cycle CPU load path).
REQ-014 Writes SHALL take effect at the rising clk edge where mem_w=1.
REQ-015 A read of a RAM word written in the same cycle SHALL return the old value.
REQ-016 Unmapped reads and TXDATA reads SHALL return 0; unmapped writes SHALL be ignored.
REQ-017 LED write SHALL load wdata[15:0]; read SHALL return {16'h0, led}.
REQ-018 CYCLE SHALL increment by 1 every cycle and wrap 0xFFFF_FFFF to 0.
REQ-019 A CYCLE write SHALL load wdata in place of that cycle's increment.
REQ-020 A TXDATA write SHALL push wdata[7:0] into a 4-entry TX FIFO.
REQ-021 A push SHALL be accepted if the FIFO is not full or a pop occurs in the same cycle.
REQ-022 A push that is not accepted SHALL drop the byte and set sticky overflow.
REQ-023 STATUS read SHALL return bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bit3 overflow, all other bits 0.
REQ-024 A STATUS write with wdata[3]=1 SHALL clear overflow; an overflow event in the same cycle SHALL win.
REQ-025 The UART FSM SHALL have states IDLE, START, DATA, STOP.
REQ-026 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte and enter START on the next cycle.
REQ-027 START SHALL drive 0, each of the 8 DATA bits (LSB first) SHALL be driven, and STOP SHALL drive 1, each for exactly CLKS_PER_BIT cycles.
REQ-028 At the end of STOP, the FSM SHALL pop and enter START directly if the FIFO is non-empty (back-to-back frames), else enter IDLE.
REQ-029 uart_tx SHALL be 1 in IDLE; tx_busy SHALL equal (state != IDLE).
REQ-030 A frame SHALL occupy 10*CLKS_PER_BIT cycles, from START entry to STOP exit.

Reset
REQ-031 While reset=0, asynchronously: led=0, CYCLE=0, FIFO empty, overflow=0, FSM=IDLE, uart_tx=1.
REQ-032 Reset asserted mid-frame SHALL abort the frame, with uart_tx high immediately.
REQ-033 RAM contents SHALL NOT be reset.
REQ-034 After reset deasserts, CYCLE SHALL read 1 at the first edge.

Structure
REQ-035 The shared definitions include file (alongside ctrl_encode_def.v) SHALL hold the MMIO address constants, STATUS bit positions and UART state encodings.
REQ-036 The UART serializer (FSM, baud counter, bit counter, shift register) SHALL be sub-module uart_tx_core, handshaking with the FIFO via valid/pop.
REQ-037 The FIFO, address decode, RAM, LED and CYCLE logic SHALL reside in dmem_mmio.

Verification (CLKS_PER_BIT=4 for the bench)
REQ-038 Bench SHALL cover: write 0xDEADBEEF to 0x0000_0010, then read it -> rdata=0xDEADBEEF; same-cycle read during the write -> old value.
REQ-039 Bench SHALL cover: TXDATA write 0xA5 -> uart_tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; tx_busy=1 throughout, 0 afterwards.
REQ-040 Bench SHALL cover: 6 back-to-back TXDATA writes -> 5 bytes transmitted (1 popped immediately + 4 queued), overflow=1, STATUS bit0=1 after the sixth write; STATUS write 0x8 -> bit3=0.
REQ-041 Bench SHALL cover: CYCLE write 0xFFFF_FFFE -> reads 0xFFFF_FFFF then 0x0000_0000 on the following cycles.
REQ-042 Bench SHALL cover: reset=0 asserted during DATA bit 3 -> uart_tx=1 with no clock edge, STATUS=0x2, led=0.
REQ-043 Bench SHALL cover: read of 0x0001_0000 -> 0, and a write to it leaves RAM and registers unchanged.
